// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable CMD/ADDR/PAYLOAD field widths and all four SPI modes, oversampled in sysclk.
// Returns i_slv_frame on MISO in the same transaction; flags aborted frames and overrun clocks.
`timescale 1ns/1ps
module spi_slave_cfg #(
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8,
    parameter bit CPOL         = 1'b0,
    parameter bit CPHA         = 1'b0,
    parameter int SYNC_STAGES  = 2,
    localparam int FRAME_W     = CMD_BITS + ADDR_BITS + PAYLOAD_BITS
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    input  logic                    slv_tx_enb,
    input  logic [FRAME_W-1:0]      i_slv_frame,
    output logic [CMD_BITS-1:0]     o_cmd,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_payload,
    output logic                    o_rx_valid,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic                    o_busy
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(CMD_BITS + ADDR_BITS);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_W);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_PAYLOAD, S_HOLD} state_t;

    logic [1:0]             r_rst_sync;
    logic                   w_rst;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_W-2:0]     r_rx_shift;
    logic [FRAME_W-1:0]     r_tx_shift;
    logic                   r_miso;
    logic                   r_ovr_seen;

    logic                   w_sclk_rise, w_sclk_fall, w_lead, w_trail;
    logic                   w_sample, w_shift, w_cs_fall, w_cs_rise, w_mosi, w_last;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [FRAME_W-1:0]     w_rx_nxt;
    logic [FRAME_W-1:0]     w_load;

    // Reset asserts immediately and releases on a sysclk edge.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) r_rst_sync <= 2'b11;
        else     r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
    assign w_rst = r_rst_sync[1];

    always_ff @(posedge sysclk or posedge w_rst) begin
        if (w_rst) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead : w_trail;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-2] & r_cs_sync[SYNC_STAGES-1];
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-2] & ~r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_rx_nxt    = {r_rx_shift, w_mosi};
    assign w_last      = (w_cnt_nxt == FRAME_END);
    assign w_load      = slv_tx_enb ? i_slv_frame : '0;
    assign miso        = r_miso;

    always_ff @(posedge sysclk or posedge w_rst) begin
        if (w_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            r_ovr_seen  <= 1'b0;
            o_cmd       <= '0;
            o_addr      <= '0;
            o_payload   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_state    <= S_CMD;
                        o_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        r_ovr_seen <= 1'b0;
                        // Mode CPHA=0 must present the MSB before the first clock edge.
                        if (CPHA == 1'b0) begin
                            r_miso     <= w_load[FRAME_W-1];
                            r_tx_shift <= {w_load[FRAME_W-2:0], 1'b0};
                        end else begin
                            r_tx_shift <= w_load;
                        end
                    end
                end
                S_CMD, S_ADDR, S_PAYLOAD: begin
                    if (w_sample && w_last) begin
                        r_cnt      <= w_cnt_nxt;
                        r_rx_shift <= w_rx_nxt[FRAME_W-2:0];
                        r_miso     <= 1'b0;
                        o_cmd      <= w_rx_nxt[PAYLOAD_BITS+ADDR_BITS +: CMD_BITS];
                        o_addr     <= w_rx_nxt[PAYLOAD_BITS +: ADDR_BITS];
                        o_payload  <= w_rx_nxt[PAYLOAD_BITS-1:0];
                        o_rx_valid <= 1'b1;
                        if (w_cs_rise) begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (w_cs_rise) begin
                        o_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        o_busy      <= 1'b0;
                        r_miso      <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_cnt      <= w_cnt_nxt;
                            r_rx_shift <= w_rx_nxt[FRAME_W-2:0];
                            if (w_cnt_nxt == CMD_END)
                                r_state <= S_ADDR;
                            else if (w_cnt_nxt == ADDR_END)
                                r_state <= S_PAYLOAD;
                        end
                        if (w_shift) begin
                            r_miso     <= r_tx_shift[FRAME_W-1];
                            r_tx_shift <= {r_tx_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                S_HOLD: begin
                    r_miso <= 1'b0;
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_sample && !r_ovr_seen) begin
                        o_overrun  <= 1'b1;
                        r_ovr_seen <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_slave_cfg.md
Name: spi_slave_cfg

Overview:
Parametrised successor to the fixed-format LED-control SPI slave. It receives a CMD/ADDR/PAYLOAD frame of configurable field widths in any of the four SPI modes, and returns a frame on MISO in the same transaction. All logic runs in the 125 MHz sysclk domain, with SCLK, CS and MOSI oversampled. It sits between the board SPI pins and the LED command decoder, and adds abort detection and overrun flagging.

Parameters:
CMD_BITS, 8, width of command field (first field on the wire)
ADDR_BITS, 8, width of address field
PAYLOAD_BITS, 8, width of payload field
CPOL, 0, SCLK idle level (0 or 1)
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, synchroniser depth for sclk/cs/mosi (minimum 2)

Ports:
sysclk  in  1  system clock, 125 MHz
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock from master, at most sysclk/8
cs  in  1  chip select, active low
mosi  in  1  master-out serial data
miso  out  1  slave-out serial data
slv_tx_enb  in  1  high = return i_slv_frame; low = return zeros
i_slv_frame  in  FRAME_W  return frame; FRAME_W = CMD_BITS+ADDR_BITS+PAYLOAD_BITS
o_cmd  out  CMD_BITS  last complete command
o_addr  out  ADDR_BITS  last complete address
o_payload  out  PAYLOAD_BITS  last complete payload
o_rx_valid  out  1  one-cycle pulse when o_cmd/o_addr/o_payload update
o_frame_err  out  1  one-cycle pulse when CS rises mid-frame
o_overrun  out  1  one-cycle pulse on first sample edge after a complete frame, same CS window
o_busy  out  1  high while the FSM is outside IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, counters and shift registers 0, synchronisers preset to the inactive levels (sclk=CPOL, cs=1).
- sclk, cs and mosi each pass through a SYNC_STAGES flop chain. Edges are detected from the last two synchronised sclk stages.
- Leading edge = rising if CPOL=0, falling if CPOL=1.
- Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge is the opposite edge.
- MOSI is sampled from the synchronised mosi in the same cycle the sample edge is detected. Fields are MSB first, in the order CMD, ADDR, PAYLOAD.
- FSM states: IDLE, CMD, ADDR, PAYLOAD, HOLD.
- IDLE -> CMD on synchronised cs falling. On this transition the block clears the bit counter and loads the tx shift register with i_slv_frame if slv_tx_enb=1, else 0.
- CMD -> ADDR after CMD_BITS samples. ADDR -> PAYLOAD after ADDR_BITS samples. PAYLOAD -> HOLD after PAYLOAD_BITS samples.
- Bit counter is clog2(FRAME_W+1) wide and counts samples across the whole frame. Field boundaries are compared against cumulative widths.
- o_rx_valid pulses exactly 1 sysclk after the cycle that detects the last sample edge. o_cmd, o_addr and o_payload update in that same cycle and hold until the next complete frame. They are not cleared by CS deassert.
- HOLD: further sample edges are ignored. o_overrun pulses once on the first extra sample edge. HOLD -> IDLE on cs rise.
- cs rise in CMD, ADDR or PAYLOAD: o_frame_err pulses 1 cycle, outputs keep their previous values, no o_rx_valid, FSM -> IDLE.
- cs rise together with the last sample edge in the same cycle: the frame counts as complete (o_rx_valid, no o_frame_err).
- MISO when CPHA=0: the MSB is driven in the cycle after the load at cs fall. Each shift edge then presents the next bit.
- MISO when CPHA=1: the first shift (leading) edge presents the MSB.
- After FRAME_W bits, or when cs is high, miso = 0. MISO is not tristated; the top level handles that.
- i_slv_frame and slv_tx_enb are sampled only at the IDLE->CMD transition. Later changes do not affect the current transaction.
- Back-to-back frames: cs high for at least SYNC_STAGES+2 sysclk cycles between frames.

Test Plan:
- Mode 0, 24-bit frame 0xA5_03_7F at sclk = sysclk/10 -> o_cmd=0xA5, o_addr=0x03, o_payload=0x7F, a single o_rx_valid pulse, o_frame_err=0.
- Mode 3 (CPOL=1, CPHA=1), slv_tx_enb=1, i_slv_frame=0xC3_00_FF, MOSI=0x01_02_03 -> master captures 0xC300FF on MISO, o_cmd=0x01, o_addr=0x02, o_payload=0x03.
- After a good frame 0x11_22_33, CS rises after 10 bits of 0xFF_FF_FF -> o_frame_err pulse, no o_rx_valid, outputs stay 0x11/0x22/0x33, o_busy=0 within 4 cycles of the synchronised cs.
- 26 clocks in one CS window, frame 0x0F_F0_AA + 2 bits -> o_rx_valid once with 0x0F/0xF0/0xAA, then one o_overrun pulse, no o_frame_err.
- Parameter set CMD_BITS=4, ADDR_BITS=4, PAYLOAD_BITS=16, mode 1, frame 0x9_6_BEEF -> o_cmd=0x9, o_addr=0x6, o_payload=0xBEEF.
- rst asserted mid-ADDR with no sysclk edge -> all outputs 0 immediately. After release, the next full frame 0x5A_5A_5A decodes correctly.
